tlv_i2c_arbiter: RTL and testbench

- Round-robin, transaction-level arbiter that shares one i2c_master among NUM_REQ TLV493 sensor sequencers on one SDA/SCL pair.
- Each requester presents a complete transaction descriptor. The arbiter latches the descriptor of the granted requester, drives the master's ena/addr/rw/data_wr/number_of_bytes/read_only, and reports done or error back to that requester only.
- A watchdog aborts hung transactions and resets the master.

---
 rtl/tlv_i2c_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_tlv_i2c_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlv_i2c_arbiter.sv
// tlv_i2c_arbiter: round-robin, transaction-level arbiter that shares one
// i2c_master among NUM_REQ sensor sequencers. The granted requester's
// descriptor is latched and frozen for the whole transaction. A watchdog
// aborts hung transfers and pulses the master's reset.
module tlv_i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 500_000,
  parameter int RESET_HOLD     = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [7*NUM_REQ-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]      req_rw,
  input  logic [NUM_REQ-1:0]      req_read_only,
  input  logic [8*NUM_REQ-1:0]    req_nbytes,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_REQ-1:0]      err,
  output logic                    timeout,
  output logic                    m_ena,
  output logic                    m_rw,
  output logic                    m_read_only,
  output logic [6:0]              m_addr,
  output logic [7:0]              m_nbytes,
  output logic [31:0]             m_wdata,
  output logic                    m_reset_n,
  input  logic                    m_busy,
  input  logic                    m_ack_error,
  input  logic [7:0]              m_byte_counter
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;

  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RELEASE,
    S_ABORT
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 timeout_q, timeout_d;
  logic                 ena_q, ena_d;
  logic                 rw_q, rw_d;
  logic                 ro_q, ro_d;
  logic [6:0]           addr_q, addr_d;
  logic [7:0]           nbytes_q, nbytes_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 mrst_q, mrst_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic                 found;
  logic [PTR_W-1:0]     pick_idx;
  int                   scan_idx;
  int                   sel;

  // Round-robin search: first active request at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    found    = 1'b0;
    pick_idx = '0;
    scan_idx = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = (int'(rr_ptr_q) + off) % NUM_REQ;
      if (!found && req[scan_idx]) begin
        found    = 1'b1;
        pick_idx = PTR_W'(scan_idx);
      end
    end
  end

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = '0;
    timeout_d = timeout_q;
    ena_d     = ena_q;
    rw_d      = rw_q;
    ro_d      = ro_q;
    addr_d    = addr_q;
    nbytes_d  = nbytes_q;
    wdata_d   = wdata_q;
    mrst_d    = mrst_q;
    rr_ptr_d  = rr_ptr_q;
    wd_d      = wd_q;
    hold_d    = hold_q;
    sel       = int'(pick_idx);

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d  = NUM_REQ'(1) << pick_idx;
          addr_d   = req_addr[7*sel +: 7];
          rw_d     = req_rw[sel];
          ro_d     = req_read_only[sel];
          nbytes_d = req_nbytes[8*sel +: 8];
          wdata_d  = req_wdata[32*sel +: 32];
          ena_d    = 1'b1;
          wd_d     = '0;
          rr_ptr_d = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        // Descriptor registers are deliberately not touched here: requester
        // inputs may change freely while the transfer is in flight.
        wd_d = wd_q + 1'b1;
        if (m_ack_error) begin
          ena_d   = 1'b0;
          err_d   = grant_q;
          state_d = S_RELEASE;
        end else if (ena_q && (m_byte_counter >= nbytes_q)) begin
          ena_d   = 1'b0;
          done_d  = grant_q;
          state_d = S_RELEASE;
        end else if (wd_q == WD_LAST) begin
          ena_d     = 1'b0;
          err_d     = grant_q;
          timeout_d = 1'b1;
          mrst_d    = 1'b0;
          hold_d    = '0;
          state_d   = S_ABORT;
        end
      end

      S_RELEASE: begin
        // Grant drops here but a new owner is only chosen from IDLE, which
        // guarantees an idle clock between owners.
        if (!m_busy) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end

      S_ABORT: begin
        if (hold_q == HOLD_LAST) begin
          mrst_d  = 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
      ena_q     <= 1'b0;
      rw_q      <= 1'b0;
      ro_q      <= 1'b0;
      addr_q    <= '0;
      nbytes_q  <= '0;
      wdata_q   <= '0;
      mrst_q    <= 1'b1;
      rr_ptr_q  <= '0;
      wd_q      <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      ena_q     <= ena_d;
      rw_q      <= rw_d;
      ro_q      <= ro_d;
      addr_q    <= addr_d;
      nbytes_q  <= nbytes_d;
      wdata_q   <= wdata_d;
      mrst_q    <= mrst_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_q      <= wd_d;
      hold_q    <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign timeout     = timeout_q;
  assign m_ena       = ena_q;
  assign m_rw        = rw_q;
  assign m_read_only = ro_q;
  assign m_addr      = addr_q;
  assign m_nbytes    = nbytes_q;
  assign m_wdata     = wdata_q;
  assign m_reset_n   = mrst_q;

endmodule

// File: tb/tb_tlv_i2c_arbiter.sv
// tb_tlv_i2c_arbiter: directed scenarios plus randomized transactions for
// tlv_i2c_arbiter, checked against a transaction-level reference model.
module tb_tlv_i2c_arbiter;

  localparam int N          = 4;
  localparam int TB_TIMEOUT = 100;
  localparam int TB_HOLD    = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [7*N-1:0]  req_addr;
  logic [N-1:0]    req_rw;
  logic [N-1:0]    req_read_only;
  logic [8*N-1:0]  req_nbytes;
  logic [32*N-1:0] req_wdata;
  logic [N-1:0]    grant, done, err;
  logic            timeout, m_ena, m_rw, m_read_only, m_reset_n;
  logic [6:0]      m_addr;
  logic [7:0]      m_nbytes;
  logic [31:0]     m_wdata;
  logic            m_busy, m_ack_error;
  logic [7:0]      m_byte_counter;

  int checks = 0;
  int errors = 0;

  // Reference model: round-robin pointer and descriptor copies.
  int          model_ptr;
  logic [6:0]  d_addr   [N];
  logic        d_rw     [N];
  logic        d_ro     [N];
  logic [7:0]  d_nbytes [N];
  logic [31:0] d_wdata  [N];

  tlv_i2c_arbiter #(
    .NUM_REQ(N), .TIMEOUT_CYCLES(TB_TIMEOUT), .RESET_HOLD(TB_HOLD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_rw(req_rw), .req_read_only(req_read_only), .req_nbytes(req_nbytes),
    .req_wdata(req_wdata), .grant(grant), .done(done), .err(err),
    .timeout(timeout), .m_ena(m_ena), .m_rw(m_rw), .m_read_only(m_read_only),
    .m_addr(m_addr), .m_nbytes(m_nbytes), .m_wdata(m_wdata),
    .m_reset_n(m_reset_n), .m_busy(m_busy), .m_ack_error(m_ack_error),
    .m_byte_counter(m_byte_counter)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached without summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // The requester chosen: first pending one at or after the pointer.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_desc(input int i, input logic [6:0] a, input logic rw,
                          input logic ro, input logic [7:0] nb, input logic [31:0] wd);
    d_addr[i] = a; d_rw[i] = rw; d_ro[i] = ro; d_nbytes[i] = nb; d_wdata[i] = wd;
    req_addr[7*i +: 7]    = a;
    req_rw[i]             = rw;
    req_read_only[i]      = ro;
    req_nbytes[8*i +: 8]  = nb;
    req_wdata[32*i +: 32] = wd;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req = '0; m_busy = 1'b0; m_ack_error = 1'b0; m_byte_counter = '0;
    tick(); tick();
    reset_n = 1'b1;
    model_ptr = 0;
  endtask

  // Waits up to 20 clocks for a grant; cycles = 0 means none appeared.
  task automatic wait_grant(output logic [N-1:0] g, output int cycles);
    g = '0; cycles = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (grant != '0) begin g = grant; cycles = c; return; end
    end
  endtask

  // Behaves as the i2c master: byte counter advances one per clock, an
  // optional ack error at step ack_at, busy lingers extra_busy clocks.
  task automatic serve(input int ack_at, input int extra_busy,
                       output logic [N-1:0] p_done, output logic [N-1:0] p_err,
                       output logic p_ena, output int steps,
                       output logic [N-1:0] after_pulse, output int rel_cycles);
    int hold;
    p_done = '0; p_err = '0; p_ena = 1'b1; steps = 0; after_pulse = '1; rel_cycles = 0;
    m_busy = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      m_byte_counter = 8'(k);
      m_ack_error    = (k == ack_at);
      tick();
      if (done != '0 || err != '0) begin
        p_done = done; p_err = err; p_ena = m_ena; steps = k;
        break;
      end
    end
    m_ack_error = 1'b0;
    hold = extra_busy;
    for (int c = 1; c <= 20; c++) begin
      m_busy = (hold > 0);
      if (hold > 0) hold--;
      tick();
      if (c == 1) after_pulse = done | err;
      if (grant == '0) begin rel_cycles = c; break; end
    end
    m_byte_counter = '0;
    m_busy = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; m_busy = 1'b0; m_ack_error = 1'b0; m_byte_counter = '0;
    for (int i = 0; i < N; i++) set_desc(i, 7'h7F, 1'b1, 1'b1, 8'hFF, 32'hFFFF_FFFF);
    tick(); tick();
    checks++;
    if ({grant, done, err} !== '0) begin
      errors++; $display("FAIL reset_handshake grant=%b done=%b err=%b want 0", grant, done, err);
    end
    checks++;
    if (timeout !== 1'b0 || m_ena !== 1'b0) begin
      errors++; $display("FAIL reset_flags timeout=%b m_ena=%b want 0", timeout, m_ena);
    end
    checks++;
    if ({m_addr, m_rw, m_read_only, m_nbytes, m_wdata} !== '0) begin
      errors++; $display("FAIL reset_desc addr=%h rw=%b ro=%b nb=%h wd=%h want 0",
                         m_addr, m_rw, m_read_only, m_nbytes, m_wdata);
    end
    checks++;
    if (m_reset_n !== 1'b1) begin
      errors++; $display("FAIL reset_mreset m_reset_n=%b want 1", m_reset_n);
    end
    reset_n = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_single();
    logic [N-1:0] g, pd, pe, ap;
    logic pena;
    int cyc, steps, rel;
    apply_reset();
    set_desc(0, 7'h5E, 1'b1, 1'b0, 8'd7, 32'h0000_00A5);
    req = 4'b0001;
    wait_grant(g, cyc);
    checks++;
    if (g !== 4'b0001 || cyc != 1 || m_ena !== 1'b1 || m_addr !== 7'h5E || m_rw !== 1'b1
        || m_nbytes !== 8'd7) begin
      errors++; $display("FAIL single_grant grant=%b cyc=%0d ena=%b addr=%h rw=%b nb=%0d want 0001/1/1/5e/1/7",
                         g, cyc, m_ena, m_addr, m_rw, m_nbytes);
    end
    model_ptr = 1;
    serve(0, 1, pd, pe, pena, steps, ap, rel);
    req = '0;
    checks++;
    if (pd !== 4'b0001 || pe !== '0 || steps != 7 || pena !== 1'b0) begin
      errors++; $display("FAIL single_done done=%b err=%b step=%0d ena=%b want 0001/0000/7/0",
                         pd, pe, steps, pena);
    end
    checks++;
    if (ap !== '0 || rel != 2) begin
      errors++; $display("FAIL single_release after=%b rel=%0d want 0000/2", ap, rel);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g, pd, pe, ap;
    logic pena;
    int cyc, steps, rel, exp_o;
    apply_reset();
    for (int i = 0; i < N; i++) set_desc(i, 7'(8'h10 + i), 1'b0, 1'b0, 8'd3, 32'(i));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_o = model_pick(req, model_ptr);
      model_ptr = (exp_o + 1) % N;
      wait_grant(g, cyc);
      checks++;
      if (g !== 4'(1 << exp_o) || cyc != 1 || m_addr !== d_addr[exp_o]) begin
        errors++; $display("FAIL rr_grant_%0d grant=%b cyc=%0d addr=%h want %b/1/%h",
                           t, g, cyc, m_addr, 4'(1 << exp_o), d_addr[exp_o]);
      end
      serve(0, 0, pd, pe, pena, steps, ap, rel);
      checks++;
      if (pd !== g || steps != 3 || rel != 1) begin
        errors++; $display("FAIL rr_done_%0d done=%b step=%0d rel=%0d want %b/3/1",
                           t, pd, steps, rel, g);
      end
    end
    req = '0;
  endtask

  task automatic test_ack_error();
    logic [N-1:0] g, pd, pe, ap;
    logic pena;
    int cyc, steps, rel;
    apply_reset();
    set_desc(2, 7'h22, 1'b0, 1'b0, 8'd5, 32'h2222_2222);
    set_desc(3, 7'h33, 1'b1, 1'b1, 8'd2, 32'h3333_3333);
    req = 4'b1100;
    wait_grant(g, cyc);
    model_ptr = 3;
    checks++;
    if (g !== 4'b0100) begin
      errors++; $display("FAIL ack_grant grant=%b want 0100", g);
    end
    serve(1, 0, pd, pe, pena, steps, ap, rel);
    req = 4'b1000;
    checks++;
    if (pe !== 4'b0100 || pd !== '0 || steps != 1 || pena !== 1'b0 || ap !== '0) begin
      errors++; $display("FAIL ack_err err=%b done=%b step=%0d ena=%b after=%b want 0100/0000/1/0/0000",
                         pe, pd, steps, pena, ap);
    end
    wait_grant(g, cyc);
    checks++;
    if (g !== 4'b1000 || m_addr !== 7'h33 || m_read_only !== 1'b1) begin
      errors++; $display("FAIL ack_next grant=%b addr=%h ro=%b want 1000/33/1", g, m_addr, m_read_only);
    end
    model_ptr = 0;
    serve(0, 0, pd, pe, pena, steps, ap, rel);
    req = '0;
  endtask

  task automatic test_freeze();
    logic [N-1:0] g, pd, pe, ap;
    logic pena;
    int cyc, steps, rel;
    bit frozen_ok;
    apply_reset();
    set_desc(1, 7'h41, 1'b0, 1'b0, 8'd4, 32'h1122_3344);
    req = 4'b0010;
    wait_grant(g, cyc);
    model_ptr = 2;
    checks++;
    if (g !== 4'b0010 || m_wdata !== 32'h1122_3344) begin
      errors++; $display("FAIL freeze_grant grant=%b wdata=%h want 0010/11223344", g, m_wdata);
    end
    set_desc(1, 7'h42, 1'b1, 1'b1, 8'd9, 32'hDEAD_BEEF);
    req = '0;
    m_busy = 1'b1;
    frozen_ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      m_byte_counter = 8'(k);
      if (k == 2) req = 4'b0010;
      tick();
      if (k < 4 && (m_wdata !== 32'h1122_3344 || grant !== 4'b0010 || done !== '0))
        frozen_ok = 1'b0;
    end
    checks++;
    if (!frozen_ok || done !== 4'b0010 || m_wdata !== 32'h1122_3344) begin
      errors++; $display("FAIL freeze_hold ok=%0d done=%b wdata=%h want 1/0010/11223344",
                         frozen_ok, done, m_wdata);
    end
    m_busy = 1'b0; m_byte_counter = '0;
    tick();
    checks++;
    if (grant !== '0) begin
      errors++; $display("FAIL freeze_release grant=%b want 0000", grant);
    end
    wait_grant(g, cyc);
    checks++;
    if (g !== 4'(1 << model_pick(4'b0010, model_ptr)) || cyc != 1 || m_wdata !== 32'hDEAD_BEEF
        || m_nbytes !== 8'd9) begin
      errors++; $display("FAIL freeze_regrant grant=%b cyc=%0d wdata=%h nb=%0d want 0010/1/deadbeef/9",
                         g, cyc, m_wdata, m_nbytes);
    end
    model_ptr = 2;
    serve(0, 0, pd, pe, pena, steps, ap, rel);
    req = '0;
  endtask

  task automatic test_timeout();
    logic [N-1:0] g;
    int cyc, cnt, low;
    apply_reset();
    set_desc(1, 7'h5E, 1'b1, 1'b0, 8'd7, 32'h0);
    req = 4'b0010;
    m_busy = 1'b1; m_byte_counter = '0;
    wait_grant(g, cyc);
    cnt = 0;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (err != '0 || done != '0) begin cnt = c; break; end
    end
    req = '0;
    checks++;
    if (cnt != TB_TIMEOUT || err !== 4'b0010 || done !== '0) begin
      errors++; $display("FAIL timeout_when clocks=%0d err=%b done=%b want %0d/0010/0000",
                         cnt, err, done, TB_TIMEOUT);
    end
    checks++;
    if (timeout !== 1'b1 || m_reset_n !== 1'b0 || m_ena !== 1'b0) begin
      errors++; $display("FAIL timeout_flags timeout=%b m_reset_n=%b ena=%b want 1/0/0",
                         timeout, m_reset_n, m_ena);
    end
    low = (m_reset_n === 1'b0) ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1 && err !== '0) low = 100;
      if (m_reset_n === 1'b0) low++;
      else break;
    end
    checks++;
    if (low != TB_HOLD || grant !== '0 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_hold low=%0d grant=%b timeout=%b want %0d/0000/1",
                         low, grant, timeout, TB_HOLD);
    end
    m_busy = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] g, seen;
    int cyc;
    apply_reset();
    set_desc(0, 7'h1A, 1'b1, 1'b1, 8'd5, 32'hCAFE_F00D);
    req = 4'b0001;
    wait_grant(g, cyc);
    m_busy = 1'b1;
    m_byte_counter = 8'd1; tick();
    m_byte_counter = 8'd2; tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({grant, done, err} !== '0 || m_ena !== 1'b0 || m_reset_n !== 1'b1 || timeout !== 1'b0
        || {m_addr, m_rw, m_read_only, m_nbytes, m_wdata} !== '0) begin
      errors++; $display("FAIL midreset_outputs grant=%b done=%b err=%b ena=%b mrst=%b to=%b wd=%h want reset values",
                         grant, done, err, m_ena, m_reset_n, timeout, m_wdata);
    end
    reset_n = 1'b1; req = '0; m_busy = 1'b0; m_byte_counter = '0;
    model_ptr = 0;
    seen = '0;
    for (int c = 0; c < 3; c++) begin tick(); seen |= done | err | grant; end
    checks++;
    if (seen !== '0) begin
      errors++; $display("FAIL midreset_quiet pulses=%b want 0000", seen);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] g, pd, pe, ap, pending;
    logic pena;
    int cyc, steps, rel, o, eff, ack_at, extra;
    apply_reset();
    pending = '0;
    for (int it = 0; it < 40; it++) begin
      pending |= 4'($urandom_range(0, 15));
      if (pending == '0) pending = 4'(1 << $urandom_range(0, N-1));
      for (int i = 0; i < N; i++)
        set_desc(i, 7'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 6)), $urandom);
      req = pending;
      o = model_pick(pending, model_ptr);
      model_ptr = (o + 1) % N;
      wait_grant(g, cyc);
      checks++;
      if (g !== 4'(1 << o) || cyc != 1) begin
        errors++; $display("FAIL rand_grant_%0d grant=%b cyc=%0d want %b/1", it, g, cyc, 4'(1 << o));
      end
      checks++;
      if ({m_addr, m_rw, m_read_only, m_nbytes, m_wdata} !==
          {d_addr[o], d_rw[o], d_ro[o], d_nbytes[o], d_wdata[o]}) begin
        errors++; $display("FAIL rand_desc_%0d got %h/%b/%b/%h/%h want %h/%b/%b/%h/%h", it,
                           m_addr, m_rw, m_read_only, m_nbytes, m_wdata,
                           d_addr[o], d_rw[o], d_ro[o], d_nbytes[o], d_wdata[o]);
      end
      eff    = (d_nbytes[o] == 0) ? 1 : int'(d_nbytes[o]);
      ack_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, eff)) : 0;
      extra  = $urandom_range(0, 2);
      serve(ack_at, extra, pd, pe, pena, steps, ap, rel);
      pending &= ~4'(1 << o);
      checks++;
      if (ack_at != 0) begin
        if (pe !== 4'(1 << o) || pd !== '0 || steps != ack_at) begin
          errors++; $display("FAIL rand_err_%0d err=%b done=%b step=%0d want %b/0000/%0d",
                             it, pe, pd, steps, 4'(1 << o), ack_at);
        end
      end else begin
        if (pd !== 4'(1 << o) || pe !== '0 || steps != eff) begin
          errors++; $display("FAIL rand_done_%0d done=%b err=%b step=%0d want %b/0000/%0d",
                             it, pd, pe, steps, 4'(1 << o), eff);
        end
      end
      checks++;
      if (ap !== '0 || rel != extra + 1 || pena !== 1'b0) begin
        errors++; $display("FAIL rand_release_%0d after=%b rel=%0d ena=%b want 0000/%0d/0",
                           it, ap, rel, pena, extra + 1);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ack_error();
    test_freeze();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
